fetch_buffered: RTL and testbench

FETCH_BUFFERED -- requirements
Module: fetch_buffered

---
 rtl/fetch_buffered.sv | 113 +++++++++++
 tb/tb_fetch_buffered.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_buffered                                                             |
// | Sequential instruction fetch into a small {pc, inst} FIFO with redirect.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_buffered #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h80020000,
  parameter int                    DEPTH      = 4,
  parameter int                    PC_STEP    = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       stall_in,
  input  logic                       redirect_in,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc_in,
  output logic                       mem_req_out,
  output logic [ADDR_WIDTH-1:0]      mem_addr_out,
  output logic                       rw_out,
  output logic [1:0]                 access_size_out,
  input  logic [DATA_WIDTH-1:0]      mem_data_in,
  output logic                       inst_valid_out,
  output logic [DATA_WIDTH-1:0]      inst_out,
  output logic [ADDR_WIDTH-1:0]      pc_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int                    c_ptr_w   = $clog2(DEPTH);
  localparam int                    c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]    c_depth   = c_cnt_w'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(PC_STEP);
  localparam logic [c_ptr_w-1:0]    c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one = c_cnt_w'(1);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_inflight;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_inst_mem [DEPTH];

  logic [c_cnt_w-1:0]    w_occupancy;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;

  // An outstanding request reserves a slot, so the FIFO can never overflow.
  assign w_occupancy = r_count + {{c_ptr_w{1'b0}}, r_inflight};
  assign w_issue     = rst_n_in & ~redirect_in & (w_occupancy < c_depth);
  assign w_push      = r_inflight & ~redirect_in;
  assign w_pop       = (r_count != '0) & ~stall_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_in) begin
      r_fetch_pc <= {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_addr <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + c_pc_step;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_req_addr;
      r_inst_mem[r_wr_ptr] <= mem_data_in;
    end
  end

  assign mem_req_out     = w_issue;
  assign mem_addr_out    = r_fetch_pc;
  assign rw_out          = 1'b0;
  assign access_size_out = 2'b10;
  assign inst_valid_out  = (r_count != '0);
  assign inst_out        = r_inst_mem[r_rd_ptr];
  assign pc_out          = r_pc_mem[r_rd_ptr];
  assign count_out       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_buffered                                                          |
// | Scoreboard bench: expected fetch/consume streams against fetch_buffered.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_buffered;

  localparam logic [31:0] c_rpc  = 32'h80020000;
  localparam logic [31:0] c_wpc  = 32'hFFFFFFF8;
  localparam logic [31:0] c_mask = 32'hFFFF0000;

  typedef struct packed {
    logic        chk_req;
    logic        req;
    logic [31:0] addr;
    logic        chk_cnt;
    logic [2:0]  cnt;
    logic        chk_head;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        chk2;
    logic [31:0] addr2;
    logic        chk2h;
    logic [31:0] pc2;
  } dexp_t;

  logic        clk;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic        mem_req, rw, valid;
  logic [31:0] mem_addr, mem_data, inst, pc;
  logic [1:0]  size;
  logic [2:0]  count;

  logic        rst2_n;
  logic        mem_req2, rw2, valid2;
  logic [31:0] mem_addr2, mem_data2, inst2, pc2;
  logic [1:0]  size2;
  logic [2:0]  count2;

  dexp_t       dx;
  logic [31:0] exp_q[$];
  logic [31:0] req_q[$];
  int          tests = 0;
  int          fails = 0;

  fetch_buffered u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .stall_in(stall), .redirect_in(redirect),
    .redirect_pc_in(redirect_pc), .mem_req_out(mem_req), .mem_addr_out(mem_addr),
    .rw_out(rw), .access_size_out(size), .mem_data_in(mem_data),
    .inst_valid_out(valid), .inst_out(inst), .pc_out(pc), .count_out(count)
  );

  fetch_buffered #(.RESET_PC(c_wpc)) u_dut_wrap (
    .clk_in(clk), .rst_n_in(rst2_n), .stall_in(1'b0), .redirect_in(1'b0),
    .redirect_pc_in(32'h0), .mem_req_out(mem_req2), .mem_addr_out(mem_addr2),
    .rw_out(rw2), .access_size_out(size2), .mem_data_in(mem_data2),
    .inst_valid_out(valid2), .inst_out(inst2), .pc_out(pc2), .count_out(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after a request; otherwise drives noise.
  always @(posedge clk) mem_data  <= mem_req  ? (mem_addr ^ c_mask)  : $urandom;
  always @(posedge clk) mem_data2 <= mem_req2 ? (mem_addr2 ^ c_mask) : $urandom;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    check("rw", 64'(rw), 64'(1'b0));
    check("size", 64'(size), 64'(2'b10));
    check("rw2", 64'(rw2), 64'(1'b0));
    check("size2", 64'(size2), 64'(2'b10));
    if (!rst_n) begin
      check("req_in_reset", 64'(mem_req), 64'(1'b0));
    end else begin
      check("valid_vs_count", 64'(valid), 64'(count != 3'd0));
      check("count_max", 64'(count <= 3'd4), 64'(1'b1));
      if (redirect) begin
        check("req_on_redirect", 64'(mem_req), 64'(1'b0));
      end else begin
        if (mem_req) begin
          check("req_q_nonempty", 64'(req_q.size() != 0), 64'(1'b1));
          if (req_q.size() != 0) begin
            e = req_q.pop_front();
            check("req_addr", 64'(mem_addr), 64'(e));
          end
        end
        if (valid && !stall) begin
          check("exp_q_nonempty", 64'(exp_q.size() != 0), 64'(1'b1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pop_pc", 64'(pc), 64'(e));
            check("pop_inst", 64'(inst), 64'(e ^ c_mask));
          end
        end
      end
    end
    if (dx.chk_req) begin
      check("d_req", 64'(mem_req), 64'(dx.req));
      if (dx.req) check("d_addr", 64'(mem_addr), 64'(dx.addr));
    end
    if (dx.chk_cnt) check("d_count", 64'(count), 64'(dx.cnt));
    if (dx.chk_head) begin
      check("d_valid", 64'(valid), 64'(dx.valid));
      check("d_pc", 64'(pc), 64'(dx.pc));
      check("d_inst", 64'(inst), 64'(dx.inst));
    end
    if (dx.chk2) begin
      check("w_req", 64'(mem_req2), 64'(1'b1));
      check("w_addr", 64'(mem_addr2), 64'(dx.addr2));
    end
    if (dx.chk2h) begin
      check("w_valid", 64'(valid2), 64'(1'b1));
      check("w_pc", 64'(pc2), 64'(dx.pc2));
      check("w_inst", 64'(inst2), 64'(dx.pc2 ^ c_mask));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dx = '0;
  endtask

  // Expected streams from a new start address: consecutive words.
  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    req_q.delete();
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(start + 32'(4 * i));
      req_q.push_back(start + 32'(4 * i));
    end
  endtask

  // Holds reset for n cycles and returns in the first cycle after release.
  task automatic do_reset(input int n);
    rst_n = 1'b0; dx.chk_req = 1'b1; dx.req = 1'b0;
    for (int i = 1; i < n; i++) begin
      step(); dx.chk_req = 1'b1; dx.req = 1'b0;
    end
    step();
    rst_n = 1'b1;
    restart(c_rpc);
    dx.chk_req = 1'b1; dx.req = 1'b1; dx.addr = c_rpc;
    dx.chk_cnt = 1'b1; dx.cnt = 3'd0;
    dx.chk_head = 1'b1; dx.valid = 1'b0; dx.pc = 32'h0; dx.inst = 32'h0;
  endtask

  task automatic expect_head(input logic [31:0] p);
    dx.chk_head = 1'b1; dx.valid = 1'b1; dx.pc = p; dx.inst = p ^ c_mask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dx = '0; rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) step();

    // Free-running from reset.
    do_reset(2);
    step(); dx.chk_head = 1'b1; dx.valid = 1'b0; dx.pc = 32'h0; dx.inst = 32'h0;
    step(); expect_head(c_rpc);
    step(); expect_head(c_rpc + 32'h4);
    repeat (8) step();

    // Stall held from reset: four requests, then saturation.
    stall = 1'b1;
    do_reset(2);
    for (int k = 1; k < 10; k++) begin
      step();
      dx.chk_req = 1'b1; dx.req = (k < 4); dx.addr = c_rpc + 32'(4 * k);
      if (k == 9) begin dx.chk_cnt = 1'b1; dx.cnt = 3'd4; end
    end
    step(); stall = 1'b0; expect_head(c_rpc); dx.chk_req = 1'b1; dx.req = 1'b0;
    step(); dx.chk_req = 1'b1; dx.req = 1'b1; dx.addr = c_rpc + 32'h10;
    repeat (8) step();

    // Redirect with three buffered entries and one in flight.
    stall = 1'b1;
    do_reset(1);
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h80020103; restart(32'h80020100);
    dx.chk_cnt = 1'b1; dx.cnt = 3'd3; dx.chk_req = 1'b1; dx.req = 1'b0;
    step(); redirect = 1'b0; stall = 1'b0;
    dx.chk_cnt = 1'b1; dx.cnt = 3'd0; dx.chk_req = 1'b1; dx.req = 1'b1; dx.addr = 32'h80020100;
    step();
    step(); expect_head(32'h80020100);
    repeat (6) step();

    // Two consecutive redirects: the second wins.
    redirect = 1'b1; redirect_pc = 32'h80030000; restart(32'h80030000);
    step(); redirect_pc = 32'h8004000A; restart(32'h80040008);
    step(); redirect = 1'b0; dx.chk_req = 1'b1; dx.req = 1'b1; dx.addr = 32'h80040008;
    step();
    step(); expect_head(32'h80040008);
    repeat (6) step();

    // One-cycle reset in the middle of the stream.
    do_reset(1);
    step();
    step(); expect_head(c_rpc);
    repeat (6) step();

    // Randomized stall / redirect / reset traffic.
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < 50; c++) begin
        step();
        stall = ($urandom_range(0, 9) < 4);
        redirect = 1'b0;
        if ($urandom_range(0, 19) == 0) begin
          redirect = 1'b1; redirect_pc = $urandom; restart(redirect_pc & 32'hFFFFFFFC);
        end
      end
      step();
      redirect = 1'b0;
      if (s % 3 == 2) begin
        do_reset(1);
      end else begin
        redirect = 1'b1; redirect_pc = $urandom; restart(redirect_pc & 32'hFFFFFFFC);
      end
    end
    step(); redirect = 1'b0; stall = 1'b0;
    repeat (10) step();

    // Address wrap from RESET_PC near the top of the space.
    rst2_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      dx.chk2 = 1'b1; dx.addr2 = c_wpc + 32'(4 * k);
      if (k >= 2) begin dx.chk2h = 1'b1; dx.pc2 = c_wpc + 32'(4 * (k - 2)); end
      step();
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
